// File: rtl/object_motion_ctrl_pkg.sv
// Shared types and constants for the object motion controller.
// Holds FSM states, crash encodings, start positions and LFSR seed.
package object_motion_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_UPD_P,
        S_UPD_E0,
        S_UPD_E1,
        S_UPD_E2,
        S_CHK_E0,
        S_CHK_E1,
        S_CHK_E2,
        S_WAIT,
        S_CRASHED
    } state_t;

    localparam logic [1:0] CRASH_RUN  = 2'b00;
    localparam logic [1:0] CRASH_HIT  = 2'b01;
    localparam logic [1:0] CRASH_IDLE = 2'b10;

    localparam logic [11:0] PLANE_X0 = 12'd200;
    localparam logic [11:0] PLANE_Y0 = 12'd360;
    localparam logic [11:0] ENEMY_X0 = 12'd1240;
    localparam logic [11:0] ENEMY_Y0 = 12'd200;
    localparam logic [11:0] PRO_X0   = 12'd1240;
    localparam logic [11:0] PRO_Y0   = 12'd400;
    localparam logic [11:0] PRO2_X0  = 12'd1240;
    localparam logic [11:0] PRO2_Y0  = 12'd600;

    localparam logic [11:0] HIT_DX      = 12'd70;
    localparam logic [11:0] HIT_DY      = 12'd90;
    localparam logic [11:0] PLANE_MX    = 12'd50;
    localparam logic [11:0] PLANE_MY    = 12'd70;
    localparam logic [11:0] WRAP_MARGIN = 12'd20;
    localparam logic [11:0] WRAP_Y_BASE = 12'd100;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [11:0] absdiff(
        input logic [11:0] a,
        input logic [11:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/object_motion_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; free-running.
// A nonzero seed on a maximal polynomial never reaches all-zero.
module lfsr16
    import object_motion_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        fb;

    always_comb begin
        fb      = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
        state_d = {state_q[14:0], fb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/object_motion_ctrl.sv
// Per-frame plane/enemy motion with wrap-around and collision detection.
// One object is updated or checked per cycle; all outputs are registered.
module object_motion_ctrl
    import object_motion_ctrl_pkg::*;
#(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int PLANE_STEP = 4,
    parameter int ENEMY_STEP = 2,
    parameter int PRO_STEP   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_start,
    output logic [11:0] PLANE_x,
    output logic [11:0] PLANE_y,
    output logic [11:0] ENEMY_x,
    output logic [11:0] ENEMY_y,
    output logic [11:0] ENEMYPRO_x,
    output logic [11:0] ENEMYPRO_y,
    output logic [11:0] ENEMYPRO_x2,
    output logic [11:0] ENEMYPRO_y2,
    output logic [1:0]  CRASH,
    output logic        busy
);

    localparam logic [11:0] X_MIN   = PLANE_MX;
    localparam logic [11:0] X_MAX   = 12'(H_ACTIVE) - PLANE_MX;
    localparam logic [11:0] Y_MIN   = PLANE_MY;
    localparam logic [11:0] Y_MAX   = 12'(V_ACTIVE) - PLANE_MY;
    localparam logic [11:0] WRAP_X  = 12'(H_ACTIVE - 1) - WRAP_MARGIN;
    localparam logic [11:0] PL_STEP = 12'(PLANE_STEP);
    localparam logic [11:0] E_STEP  = 12'(ENEMY_STEP);
    localparam logic [11:0] P_STEP  = 12'(PRO_STEP);

    state_t      state_q, state_d;
    logic [11:0] px_q, px_d, py_q, py_d;
    logic [11:0] ex_q [3];
    logic [11:0] ex_d [3];
    logic [11:0] ey_q [3];
    logic [11:0] ey_d [3];
    logic        hit_q, hit_d, hit_now;
    logic [1:0]  crash_q, crash_d;
    logic        busy_q, busy_d;
    logic [1:0]  k;
    logic [11:0] step_k;
    logic [15:0] lfsr;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:9];

    always_comb begin
        unique case (state_q)
            S_UPD_E1, S_CHK_E1: k = 2'd1;
            S_UPD_E2, S_CHK_E2: k = 2'd2;
            default:            k = 2'd0;
        endcase
        step_k = (k == 2'd0) ? E_STEP : P_STEP;
    end

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        hit_d   = hit_q;
        hit_now = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (key_start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (frame_tick) begin
                    state_d = S_UPD_P;
                    hit_d   = 1'b0;
                end
            end
            S_UPD_P: begin
                if (key_up && !key_down) begin
                    py_d = (py_q < Y_MIN + PL_STEP) ? Y_MIN : py_q - PL_STEP;
                end else if (key_down && !key_up) begin
                    py_d = (py_q + PL_STEP > Y_MAX) ? Y_MAX : py_q + PL_STEP;
                end
                if (key_left && !key_right) begin
                    px_d = (px_q < X_MIN + PL_STEP) ? X_MIN : px_q - PL_STEP;
                end else if (key_right && !key_left) begin
                    px_d = (px_q + PL_STEP > X_MAX) ? X_MAX : px_q + PL_STEP;
                end
                state_d = S_UPD_E0;
            end
            S_UPD_E0, S_UPD_E1, S_UPD_E2: begin
                // Bound check first so the subtraction never underflows
                if (ex_q[k] <= WRAP_MARGIN + step_k) begin
                    ex_d[k] = WRAP_X;
                    ey_d[k] = {3'b000, lfsr[8:0]} + WRAP_Y_BASE;
                end else begin
                    ex_d[k] = ex_q[k] - step_k;
                end
                state_d = state_t'(state_q + 4'd1);
            end
            S_CHK_E0, S_CHK_E1, S_CHK_E2: begin
                hit_now = (absdiff(px_q, ex_q[k]) <= HIT_DX) &&
                          (absdiff(py_q, ey_q[k]) <= HIT_DY);
                hit_d   = hit_q | hit_now;
                if (state_q == S_CHK_E2) begin
                    state_d = hit_d ? S_CRASHED : S_WAIT;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            S_CRASHED: begin
                if (key_start) begin
                    px_d    = PLANE_X0;
                    py_d    = PLANE_Y0;
                    ex_d    = '{ENEMY_X0, PRO_X0, PRO2_X0};
                    ey_d    = '{ENEMY_Y0, PRO_Y0, PRO2_Y0};
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (state_d)
            S_IDLE:    crash_d = CRASH_IDLE;
            S_CRASHED: crash_d = CRASH_HIT;
            default:   crash_d = CRASH_RUN;
        endcase
        busy_d = (state_d inside {S_UPD_P, S_UPD_E0, S_UPD_E1, S_UPD_E2,
                                  S_CHK_E0, S_CHK_E1, S_CHK_E2});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            px_q    <= PLANE_X0;
            py_q    <= PLANE_Y0;
            ex_q    <= '{ENEMY_X0, PRO_X0, PRO2_X0};
            ey_q    <= '{ENEMY_Y0, PRO_Y0, PRO2_Y0};
            hit_q   <= 1'b0;
            crash_q <= CRASH_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            hit_q   <= hit_d;
            crash_q <= crash_d;
            busy_q  <= busy_d;
        end
    end

    assign PLANE_x     = px_q;
    assign PLANE_y     = py_q;
    assign ENEMY_x     = ex_q[0];
    assign ENEMY_y     = ey_q[0];
    assign ENEMYPRO_x  = ex_q[1];
    assign ENEMYPRO_y  = ey_q[1];
    assign ENEMYPRO_x2 = ex_q[2];
    assign ENEMYPRO_y2 = ey_q[2];
    assign CRASH       = crash_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_object_motion_ctrl.sv
// Directed bench for object_motion_ctrl: motion, clamps, wrap,
// crash/restart, ignored ticks and mid-frame reset.
module tb_object_motion_ctrl;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        key_up, key_down, key_left, key_right, key_start;
    logic [11:0] PLANE_x, PLANE_y, ENEMY_x, ENEMY_y;
    logic [11:0] ENEMYPRO_x, ENEMYPRO_y, ENEMYPRO_x2, ENEMYPRO_y2;
    logic [1:0]  CRASH;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int nf    = 0;

    object_motion_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_start   (key_start),
        .PLANE_x     (PLANE_x),
        .PLANE_y     (PLANE_y),
        .ENEMY_x     (ENEMY_x),
        .ENEMY_y     (ENEMY_y),
        .ENEMYPRO_x  (ENEMYPRO_x),
        .ENEMYPRO_y  (ENEMYPRO_y),
        .ENEMYPRO_x2 (ENEMYPRO_x2),
        .ENEMYPRO_y2 (ENEMYPRO_y2),
        .CRASH       (CRASH),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tick sampled on the first edge, verdict registered seven edges later
    task automatic do_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (7) step();
        nf++;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; frame_tick = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0;
        key_right = 1'b0; key_start = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        chk("rst_crash", int'(CRASH), 2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_px", int'(PLANE_x), 200);
        chk("rst_py", int'(PLANE_y), 360);
        chk("rst_ex", int'(ENEMY_x), 1240);
        chk("rst_ey", int'(ENEMY_y), 200);
        chk("rst_p1x", int'(ENEMYPRO_x), 1240);
        chk("rst_p1y", int'(ENEMYPRO_y), 400);
        chk("rst_p2x", int'(ENEMYPRO_x2), 1240);
        chk("rst_p2y", int'(ENEMYPRO_y2), 600);

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        chk("idle_crash", int'(CRASH), 2);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ex", int'(ENEMY_x), 1240);

        key_start = 1'b1;
        step();
        key_start = 1'b0;
        chk("start_crash", int'(CRASH), 0);
        chk("start_busy", int'(busy), 0);

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("f1_busy", int'(busy), 1);
        repeat (3) step();
        chk("f1_mid_ex", int'(ENEMY_x), 1238);
        chk("f1_mid_p2x", int'(ENEMYPRO_x2), 1240);
        step();
        chk("f1_upd_p2x", int'(ENEMYPRO_x2), 1237);
        repeat (3) step();
        nf++;
        chk("f1_ex", int'(ENEMY_x), 1238);
        chk("f1_p1x", int'(ENEMYPRO_x), 1237);
        chk("f1_p2x", int'(ENEMYPRO_x2), 1237);
        chk("f1_px", int'(PLANE_x), 200);
        chk("f1_py", int'(PLANE_y), 360);
        chk("f1_crash", int'(CRASH), 0);
        chk("f1_busy_end", int'(busy), 0);

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (5) step();
        repeat (3) step();
        nf++;
        chk("ign_ex", int'(ENEMY_x), 1236);
        chk("ign_busy", int'(busy), 0);
        do_frame();
        chk("f3_ex", int'(ENEMY_x), 1234);

        key_up = 1'b1;
        do_frame();
        chk("up1_py", int'(PLANE_y), 356);
        repeat (99) do_frame();
        chk("up100_py", int'(PLANE_y), 70);
        key_down = 1'b1;
        do_frame();
        chk("updn_py", int'(PLANE_y), 70);
        key_up = 1'b0;
        key_down = 1'b0;

        key_left = 1'b1;
        key_right = 1'b1;
        do_frame();
        chk("lr_px", int'(PLANE_x), 200);
        key_right = 1'b0;
        repeat (40) do_frame();
        chk("left_px", int'(PLANE_x), 50);
        key_left = 1'b0;
        key_right = 1'b1;
        do_frame();
        chk("right_px", int'(PLANE_x), 54);
        key_right = 1'b0;
        chk("mid_ex", int'(ENEMY_x), 1240 - 2 * nf);

        while (nf < 406) do_frame();
        chk("pre_p1x", int'(ENEMYPRO_x), 22);
        chk("pre_p2x", int'(ENEMYPRO_x2), 22);
        do_frame();
        chk("wrap_p1x", int'(ENEMYPRO_x), 1259);
        chk("wrap_p2x", int'(ENEMYPRO_x2), 1259);
        chk("wrap_p1y", int'(ENEMYPRO_y >= 12'd100 && ENEMYPRO_y <= 12'd611), 1);
        chk("wrap_p2y", int'(ENEMYPRO_y2 >= 12'd100 && ENEMYPRO_y2 <= 12'd611), 1);

        while (nf < 609) do_frame();
        chk("pre_ex", int'(ENEMY_x), 22);
        do_frame();
        chk("wrap_ex", int'(ENEMY_x), 1259);
        chk("wrap_ey", int'(ENEMY_y >= 12'd100 && ENEMY_y <= 12'd611), 1);
        chk("wrap_crash", int'(CRASH), 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_crash", int'(CRASH), 2);
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        nf = 0;
        while (nf < 323) do_frame();
        chk("near_crash", int'(CRASH), 0);
        chk("near_p1x", int'(ENEMYPRO_x), 271);

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (6) step();
        chk("chk2_crash", int'(CRASH), 0);
        chk("chk2_busy", int'(busy), 1);
        step();
        chk("hit_crash", int'(CRASH), 1);
        chk("hit_busy", int'(busy), 0);
        chk("hit_p1x", int'(ENEMYPRO_x), 268);

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (8) step();
        chk("frz_p1x", int'(ENEMYPRO_x), 268);
        chk("frz_ex", int'(ENEMY_x), 592);
        chk("frz_crash", int'(CRASH), 1);
        chk("frz_busy", int'(busy), 0);

        key_start = 1'b1;
        step();
        key_start = 1'b0;
        chk("rs_crash", int'(CRASH), 0);
        chk("rs_px", int'(PLANE_x), 200);
        chk("rs_p1x", int'(ENEMYPRO_x), 1240);
        chk("rs_ey", int'(ENEMY_y), 200);
        do_frame();
        chk("rs_f_ex", int'(ENEMY_x), 1238);

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_crash", int'(CRASH), 2);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ex", int'(ENEMY_x), 1240);
        chk("abort_p2x", int'(ENEMYPRO_x2), 1240);

        key_start = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        key_start = 1'b0;
        chk("prio_crash", int'(CRASH), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
